// File: rtl/spi_shift_ctrl.sv
// SPI transfer controller and shift register beside spi_clkgen.
// Serialises tx_data on shift strobes, deserialises miso on sample strobes.
module spi_shift_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 6
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               go,
  input  logic [CNT_W-1:0]   char_len,
  input  logic               lsb,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               shift,
  input  logic               sample,
  input  logic               miso,
  output logic               tip,
  output logic               mosi,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]   len_in, len_q;
  logic [CNT_W-1:0]   tx_cnt, rx_cnt;
  logic               lsb_q;
  logic [MAX_LEN-1:0] tx_q, rx_q, rx_nxt;
  logic               cap, adv, last;

  function automatic logic [CNT_W-1:0] pos(
    input logic             l,
    input logic [CNT_W-1:0] n,
    input logic [CNT_W-1:0] k
  );
    return l ? k : n - ONE - k;
  endfunction

  function automatic logic bit_at(
    input logic [MAX_LEN-1:0] w,
    input logic [CNT_W-1:0]   idx
  );
    logic [MAX_LEN-1:0] s;
    s = w >> idx;
    return s[0];
  endfunction

  always_comb begin
    len_in = char_len;
    if (char_len == '0 || char_len > LEN_MAX)
      len_in = LEN_MAX;
  end

  // shift only advances once a bit has been sampled since the last advance
  always_comb begin
    cap    = (state == XFER) && sample;
    last   = cap && (rx_cnt + ONE == len_q);
    adv    = (state == XFER) && shift &&
             (rx_cnt > tx_cnt) && (tx_cnt + ONE < len_q);
    rx_nxt = rx_q |
             (MAX_LEN'(miso) << pos(lsb_q, len_q, rx_cnt));
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tip       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (go) state_nxt = XFER;
      XFER: begin
        tip = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      mosi    <= 1'b0;
      rx_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          mosi <= 1'b0;
          if (go) begin
            len_q  <= len_in;
            lsb_q  <= lsb;
            tx_q   <= tx_data;
            tx_cnt <= '0;
            rx_cnt <= '0;
            rx_q   <= '0;
            mosi   <= bit_at(tx_data, pos(lsb, len_in, '0));
          end
        end
        XFER: begin
          if (cap) begin
            rx_q   <= rx_nxt;
            rx_cnt <= rx_cnt + ONE;
            if (last) rx_data <= rx_nxt;
          end
          if (adv) begin
            tx_cnt <= tx_cnt + ONE;
            mosi   <= bit_at(tx_q, pos(lsb_q, len_q, tx_cnt + ONE));
          end
        end
        DONE: mosi <= 1'b0;
        default: mosi <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/spi_shift_ctrl.md
Name: spi_shift_ctrl

Overview:
Transfer controller and shift register that sits directly beside spi_clkgen. It accepts a transmit word and a start pulse, and drives TIP to the clock generator. It consumes the clock generator's shift/sample strobes to serialise MOSI and deserialise MISO. When the last bit has been sampled, it drops TIP, presents the received word and pulses done.

Parameters:
MAX_LEN, 32, maximum bits per transfer; width of tx_data/rx_data.
CNT_W, 6, width of char_len and the internal bit counters; must be >= clog2(MAX_LEN)+1.

Ports:
sys_clk   input   1        system clock; all logic on rising edge
rst       input   1        asynchronous reset, active-high
go        input   1        start request; sampled only in IDLE
char_len  input   CNT_W    bits per transfer; 0 encodes MAX_LEN; values > MAX_LEN clamp to MAX_LEN
lsb       input   1        1 = LSB first, 0 = MSB first; sampled with go
tx_data   input   MAX_LEN  word to send; bits [len-1:0] used; sampled with go
shift     input   1        one-cycle strobe from spi_clkgen: drive next MOSI bit
sample    input   1        one-cycle strobe from spi_clkgen: capture MISO
miso      input   1        serial data in
tip       output  1        transfer in progress; feeds spi_clkgen TIP
mosi      output  1        serial data out
rx_data   output  MAX_LEN  received word, right-aligned, upper bits zero
done      output  1        one-cycle pulse when rx_data is updated

Behaviour:
- Reset (async, rst=1): state=IDLE, tip=0, mosi=0, rx_data=0, done=0, all counters and shift registers 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - tip=0, mosi=0; shift/sample strobes are ignored.
  - On go=1: latch len (after 0/clamp rule), lsb and tx_data; clear tx_cnt, rx_cnt and the rx shift register; move to XFER.
  - Next cycle: tip=1 and mosi = first bit (tx_data[len-1] if MSB-first, tx_data[0] if LSB-first). The first bit is valid before the first SPI edge.
- XFER, sample strobe:
  - Capture miso into rx bit position len-1-rx_cnt (MSB-first) or rx_cnt (LSB-first); rx_cnt increments.
- XFER, shift strobe:
  - Advances only when rx_cnt > tx_cnt (at least one bit sampled since the last advance). Then tx_cnt increments and mosi updates to the next bit in order.
  - Otherwise the strobe is ignored. This covers the leading shift edge in CPHA=1 and the trailing shift edge after the last sample, so no CPHA input is needed.
- Same-cycle shift and sample: the sample is applied; the shift test uses the pre-sample counts.
- Completion:
  - The sample that makes rx_cnt == len moves the state to DONE on the next edge.
  - In DONE (one cycle): tip=0, rx_data <= assembled word, done=1, mosi holds the last bit.
  - Next cycle: IDLE, done=0, mosi=0.
  - Total latency from the final sample strobe to done=1 is 1 cycle.
- go while tip=1 or in DONE is ignored; no queuing.
- rx_data holds its value until the next done; no partial data is ever visible.
- Strobes arriving after tip falls (spi_clkgen pipeline lag) are ignored in DONE/IDLE.
- rst mid-transfer aborts immediately: outputs go to reset values and rx_data is cleared.
- char_len=1: one sample, no tx advance, done follows.

Test Plan:
- len=8, MSB-first, tx=0xA5, miso looped to mosi, CPHA=0 strobe order (sample then shift) -> mosi sequence 1,0,1,0,0,1,0,1; tip high throughout; done single pulse; rx_data=0x000000A5; tip=0 on the done cycle.
- len=8, LSB-first, tx=0x01, miso tied 1 -> mosi 1 then seven 0s; rx_data=0x000000FF.
- len=4, MSB-first, tx=0x9, CPHA=1 order (shift then sample), loopback -> first shift strobe does not change mosi; mosi sequence 1,0,0,1; rx_data=0x9.
- char_len=0, tx=0xDEADBEEF, loopback -> exactly 32 samples before done; rx_data=0xDEADBEEF; char_len=40 also gives 32 bits.
- go pulsed at bit 3 of an active transfer -> ignored, result unchanged. Separately, rst asserted at bit 3 -> same cycle tip=0, mosi=0, rx_data=0, done=0; a following go runs a clean transfer.
- shift/sample strobes with go=0 in IDLE, and 3 cycles after done -> rx_data, mosi and tip unchanged.
